// File: rtl/approx_mult_pipe.sv
// 3-stage valid/ready unsigned multiplier with per-transaction approximate first-layer compression.
// Define APPROX_MULT_ERR_CNT_EN to add a saturating counter of delivered err=1 results.
module approx_mult_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_COLS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 out_err
`ifdef APPROX_MULT_ERR_CNT_EN
  ,
  input  logic                 err_cnt_clr,
  output logic [15:0]          err_cnt
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = WIDTH / 4;

  logic en;

  logic             v1_reg, approx_reg;
  logic [WIDTH-1:0] a_reg, b_reg;

  logic [PW-1:0][WIDTH-1:0] sum_next, sum_reg;
  logic [PW-1:0][CW-1:0]    carry_next, carry_reg;
  logic [PW-1:0]            err_col;
  logic                     v2_reg, err2_reg;

  logic [PW-1:0] prod_next, p_reg;
  logic          v3_reg, err3_reg;

  // Global enable: every stage freezes while the output is held.
  assign en        = ~(v3_reg & ~out_ready);
  assign in_ready  = en;
  assign out_valid = v3_reg;
  assign out_p     = p_reg;
  assign out_err   = err3_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg     <= 1'b0;
      approx_reg <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else if (en) begin
      v1_reg     <= in_valid;
      approx_reg <= in_approx;
      a_reg      <= in_a;
      b_reg      <= in_b;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_col
      localparam int ILO = (gi >= WIDTH) ? gi - WIDTH + 1 : 0;
      localparam int IHI = (gi < WIDTH) ? gi : WIDTH - 1;
      localparam int N   = IHI - ILO + 1;
      localparam int NG  = N / 4;
      localparam int NR  = N % 4;
      localparam int R0  = (4 * NG     < WIDTH) ? 4 * NG     : 0;
      localparam int R1  = (4 * NG + 1 < WIDTH) ? 4 * NG + 1 : 0;
      localparam int R2  = (4 * NG + 2 < WIDTH) ? 4 * NG + 2 : 0;
      localparam int S1I = (NG + 1 < WIDTH) ? NG + 1 : 0;
      localparam bit APX = (gi < APPROX_COLS);

      logic [WIDTH-1:0] col;
      logic [WIDTH-1:0] sum_bits;
      logic [CW-1:0]    carry_bits;
      logic             col_err;

      // Column bits packed from slot 0 in ascending row order.
      always_comb begin
        col = '0;
        for (int m = 0; m < N; m++)
          col[m] = a_reg[gi-ILO-m] & b_reg[ILO+m];
      end

      always_comb begin : compress
        logic       w, x, y, z;
        logic [2:0] cnt;
        w = 1'b0; x = 1'b0; y = 1'b0; z = 1'b0;
        cnt        = '0;
        sum_bits   = col;
        carry_bits = '0;
        col_err    = 1'b0;
        if (APX && approx_reg) begin
          sum_bits = '0;
          for (int g = 0; g < NG; g++) begin
            w = col[4*g]; x = col[4*g+1]; y = col[4*g+2]; z = col[4*g+3];
            sum_bits[g]   = (w ^ x) | (y ^ z);
            carry_bits[g] = (w & x) | (y & z);
            cnt = 3'(w) + 3'(x) + 3'(y) + 3'(z);
            if ({1'b0, carry_bits[g], sum_bits[g]} != cnt)
              col_err = 1'b1;
          end
          // A 3-bit tail is an approximate half adder on the first pair plus a passed-through bit.
          if (NR == 1) begin
            sum_bits[NG] = col[R0];
          end else if (NR >= 2) begin
            sum_bits[NG] = col[R0] | col[R1];
            if (col[R0] & col[R1])
              col_err = 1'b1;
            if (NR == 3)
              sum_bits[S1I] = col[R2];
          end
        end
      end

      assign sum_next[gi]   = sum_bits;
      assign carry_next[gi] = carry_bits;
      assign err_col[gi]    = col_err;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg    <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= '0;
      err2_reg  <= 1'b0;
    end else if (en) begin
      v2_reg    <= v1_reg;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      err2_reg  <= |err_col;
    end
  end

  // Exact reduction of the compressed bit matrix; carries sit one column up, top carry wraps out.
  always_comb begin
    prod_next = '0;
    for (int k = 0; k < PW; k++) begin
      for (int m = 0; m < WIDTH; m++)
        prod_next = prod_next + (PW'(sum_reg[k][m]) << k);
      for (int m = 0; m < CW; m++)
        prod_next = prod_next + (PW'(carry_reg[k][m]) << (k + 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_reg   <= 1'b0;
      p_reg    <= '0;
      err3_reg <= 1'b0;
    end else if (en) begin
      v3_reg   <= v2_reg;
      p_reg    <= prod_next;
      err3_reg <= v2_reg & err2_reg;
    end
  end

`ifdef APPROX_MULT_ERR_CNT_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (err_cnt_clr)
      cnt_reg <= '0;
    else if (v3_reg && out_ready && err3_reg && (cnt_reg != 16'hFFFF))
      cnt_reg <= cnt_reg + 16'd1;
  end

  assign err_cnt = cnt_reg;
`endif

endmodule
